// File: rtl/btb_2bit.sv
// btb_2bit: direct-mapped branch target buffer with 2-bit counters and a reset sweep.
// Build with BTB_STATS_EN defined to add the saturating lookup and hit counters.
module btb_2bit #(
    parameter int PC    = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = PC - IDX_W - 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          lookup_valid_in,
    input  logic [PC-1:0] lookup_pc_in,
    output logic          hit_out,
    output logic          taken_out,
    output logic [PC-1:0] target_out,
    output logic          ready_out,
    input  logic          update_in,
    input  logic [PC-1:0] update_pc_in,
    input  logic          update_taken_in,
    input  logic [PC-1:0] update_target_in
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]   stat_lookups_out,
    output logic [31:0]   stat_hits_out
`endif
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             valid   [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PC-1:0]    tgt_mem [DEPTH];
    logic [1:0]       ctr_mem [DEPTH];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_match, u_hit, u_we;
    logic             unused;

    assign l_idx  = lookup_pc_in[IDX_W+1:2];
    assign l_tag  = lookup_pc_in[PC-1:IDX_W+2];
    assign u_idx  = update_pc_in[IDX_W+1:2];
    assign u_tag  = update_pc_in[PC-1:IDX_W+2];
    assign u_hit  = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    assign u_we   = (state == RUN) && !rst_in && update_in;
    assign unused = ^{lookup_pc_in[1:0], update_pc_in[1:0], lookup_valid_in};

    // Zero-latency lookup, forced to a miss until the sweep has finished.
    always_comb begin
        l_match    = ready_out && valid[l_idx] && (tag_mem[l_idx] == l_tag);
        hit_out    = l_match;
        taken_out  = l_match && ctr_mem[l_idx][1];
        target_out = l_match ? tgt_mem[l_idx] : '0;
    end

    // INIT/RUN control: sweep clears valid bits, RUN allocates on taken misses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= INIT;
            ptr       <= '0;
            ready_out <= 1'b0;
        end else if (state == INIT) begin
            valid[ptr] <= 1'b0;
            ptr        <= ptr + 1'b1;
            if (ptr == IDX_W'(DEPTH - 1)) begin
                state     <= RUN;
                ready_out <= 1'b1;
            end
        end else if (u_we && !u_hit && update_taken_in) begin
            valid[u_idx] <= 1'b1;
        end
    end

    // Payload arrays are never reset; valid bits alone qualify their contents.
    always_ff @(posedge clk_in) begin
        if (u_we && u_hit) begin
            ctr_mem[u_idx] <= update_taken_in
                ? ((ctr_mem[u_idx] == 2'd3) ? 2'd3 : ctr_mem[u_idx] + 2'd1)
                : ((ctr_mem[u_idx] == 2'd0) ? 2'd0 : ctr_mem[u_idx] - 2'd1);
            if (update_taken_in) tgt_mem[u_idx] <= update_target_in;
        end else if (u_we && update_taken_in) begin
            tag_mem[u_idx] <= u_tag;
            tgt_mem[u_idx] <= update_target_in;
            ctr_mem[u_idx] <= 2'b10;
        end
    end

`ifdef BTB_STATS_EN
    // Saturating statistics, counted only once the table is live.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_lookups_out <= '0;
            stat_hits_out    <= '0;
        end else if (ready_out && lookup_valid_in) begin
            if (stat_lookups_out != '1) stat_lookups_out <= stat_lookups_out + 32'd1;
            if (hit_out && stat_hits_out != '1) stat_hits_out <= stat_hits_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_2bit.sv
// tb_btb_2bit: scoreboard bench for btb_2bit; lookups queue expectations, a monitor checks them.
module tb_btb_2bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        hit, taken, ready;
    logic [31:0] target;
    logic        update_in = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        probe = 1'b0;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups, stat_hits;
`endif

    typedef struct {
        string       name;
        logic        r;
        logic        h;
        logic        t;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    btb_2bit dut (
        .clk_in(clk),
        .rst_in(rst),
        .lookup_valid_in(lookup_valid),
        .lookup_pc_in(lookup_pc),
        .hit_out(hit),
        .taken_out(taken),
        .target_out(target),
        .ready_out(ready),
        .update_in(update_in),
        .update_pc_in(update_pc),
        .update_taken_in(update_taken),
        .update_target_in(update_target)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups_out(stat_lookups),
        .stat_hits_out(stat_hits)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: whenever a lookup is presented, pop its expectation and compare.
    always @(negedge clk) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, {29'd0, ready, hit, taken, target}, {29'd0, e.r, e.h, e.t, e.tgt});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic r, input logic h,
                        input logic t, input logic [31:0] tg);
        exp_t e;
        e = '{nm, r, h, t, tg};
        exp_q.push_back(e);
        lookup_pc    = pc;
        lookup_valid = 1'b1;
        probe        = 1'b1;
        step();
        lookup_valid = 1'b0;
        probe        = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        update_pc     = pc;
        update_taken  = tk;
        update_target = tg;
        update_in     = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        set_upd(pc, tk, tg);
        step();
        update_in = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        forever begin
            @(negedge clk);
            if (ready || n >= 100) break;
            n++;
        end
        check(nm, 64'(n), 64'd32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        wait_ready("sweep_cycles");
        step();
        look("cold_miss", 32'h0000_1004, 1, 0, 0, 0);

        upd(32'h0000_1004, 1, 32'h0000_2000);
        look("alloc_hit", 32'h0000_1004, 1, 1, 1, 32'h0000_2000);

        upd(32'h0000_3008, 0, 32'h0000_4000);
        look("nt_miss_no_alloc", 32'h0000_3008, 1, 0, 0, 0);
        look("tag_alias_miss", 32'h0000_1084, 1, 0, 0, 0);
        look("alias_entry_kept", 32'h0000_1004, 1, 1, 1, 32'h0000_2000);

        repeat (3) upd(32'h0000_1004, 1, 32'h0000_2400);
        look("ctr3_sat", 32'h0000_1004, 1, 1, 1, 32'h0000_2400);
        upd(32'h0000_1004, 0, 32'h0000_9999);
        look("ctr2_hyst", 32'h0000_1004, 1, 1, 1, 32'h0000_2400);
        upd(32'h0000_1004, 0, 32'h0000_9999);
        look("ctr1_not_taken", 32'h0000_1004, 1, 1, 0, 32'h0000_2400);
        repeat (2) upd(32'h0000_1004, 0, 32'h0000_9999);
        look("ctr0_floor", 32'h0000_1004, 1, 1, 0, 32'h0000_2400);
        upd(32'h0000_1004, 1, 32'h0000_2400);
        look("ctr0_to_1", 32'h0000_1004, 1, 1, 0, 32'h0000_2400);
        upd(32'h0000_1004, 1, 32'h0000_2400);
        look("ctr1_to_2", 32'h0000_1004, 1, 1, 1, 32'h0000_2400);

        set_upd(32'h0000_1004, 0, 32'h0000_9999);
        look("conflict_old_ctr", 32'h0000_1004, 1, 1, 1, 32'h0000_2400);
        update_in = 1'b0;
        look("conflict_new_ctr", 32'h0000_1004, 1, 1, 0, 32'h0000_2400);
        set_upd(32'h0000_1084, 1, 32'h0000_5000);
        look("conflict_old_miss", 32'h0000_1084, 1, 0, 0, 0);
        update_in = 1'b0;
        look("replace_hit", 32'h0000_1084, 1, 1, 1, 32'h0000_5000);
        look("replaced_miss", 32'h0000_1004, 1, 0, 0, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        look("init_gate", 32'h0000_1084, 0, 0, 0, 0);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                set_upd(32'h0000_1004, 1, 32'h0000_7000);
                repeat (3) @(posedge clk);
                #1;
                update_in = 1'b0;
            end
        join_none
        wait_ready("restart_sweep_cycles");
        step();
        look("init_update_dropped", 32'h0000_1004, 1, 0, 0, 0);
        look("swept_entry_miss", 32'h0000_1084, 1, 0, 0, 0);

`ifdef BTB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("stats_sweep_cycles");
        step();
        check("stat_lookups_reset", 64'(stat_lookups), 64'd0);
        check("stat_hits_reset", 64'(stat_hits), 64'd0);
        upd(32'h0000_1004, 1, 32'h0000_2000);
        look("stat_l1", 32'h0000_1004, 1, 1, 1, 32'h0000_2000);
        look("stat_l2", 32'h0000_1004, 1, 1, 1, 32'h0000_2000);
        step();
        look("stat_l3", 32'h0000_1004, 1, 1, 1, 32'h0000_2000);
        look("stat_l4", 32'h0000_1084, 1, 0, 0, 0);
        step();
        look("stat_l5", 32'h0000_3008, 1, 0, 0, 0);
        check("stat_lookups_5", 64'(stat_lookups), 64'd5);
        check("stat_hits_3", 64'(stat_hits), 64'd3);
        rst = 1'b1;
        step();
        check("stat_lookups_clear", 64'(stat_lookups), 64'd0);
        check("stat_hits_clear", 64'(stat_hits), 64'd0);
        rst = 1'b0;
`endif

        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
